operand2_encoder: RTL and testbench
===================================

Name: operand2_encoder

Overview:
- Inverse of the Val2 generator's rotate-immediate path: takes a 32-bit constant and searches for the 12-bit ARM data-processing immediate `{rotate_imm[3:0], imm8[7:0]}`.
- Encoding rule: `value == ROR(zero-extended imm8, 2*rotate_imm)`.
- Optional fallback: finds an encoding of `~value`, so the caller can issue MVN instead of MOV.
- Multi-cycle, one rotation tested per cycle. Used by the assembler/constant-loading support logic and by verification to generate legal `shift_operand` fields.

Parameters:
- ALLOW_INV, 1, 1 = after the direct search fails, report an inverted-value hit; 0 = never report inverted hits.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-low reset
- start  input  1  request pulse; sampled only when the block is not busy
- value  input  32  constant to encode; captured on an accepted start
- busy  output  1  high while a search is in progress
- done  output  1  one-cycle pulse when the result is ready
- valid  output  1  an encoding was found; held until the next accepted start
- inv  output  1  the encoding is for `~value` (MVN form); held
- shift_operand  output  12  `{rotate_imm, imm8}`; held; 12'h000 when valid=0

Behaviour:
- Reset (rst==0 at a clk edge):
  - state=IDLE; busy, done, valid, inv = 0; shift_operand = 0; rotation counter = 0; inverted-hit record cleared.
  - Reset has priority over everything, including mid-search: any search in progress is aborted and no done is produced.
- States:
  - IDLE: busy=0.
    - start=1 → capture value into an internal register, counter r=0, clear the inverted-hit record, clear valid/inv/shift_operand, go to SEARCH.
  - SEARCH: busy=1; start is ignored; value input changes are ignored.
    - Direct test each cycle: `t = ROL(captured, 2*r)` (32-bit, wrap-around). Direct hit ⇔ `t[31:8]==0`.
    - Inverted test each cycle: same test applied to `~captured`. Only the first (lowest r) inverted hit is recorded, as `{r, imm8}`.
    - Direct hit → latch shift_operand={r, t[7:0]}, valid=1, inv=0, go to DONE. The lowest r wins (early exit).
    - No hit and r<15 → r=r+1.
    - No hit and r==15:
      - inverted record present and ALLOW_INV=1 → shift_operand=record, valid=1, inv=1.
      - otherwise → valid=0, inv=0, shift_operand=0.
      - Then go to DONE.
    - Direct and inverted hits in the same cycle: direct wins.
  - DONE: done=1 for exactly this cycle; busy=0.
    - start=1 → behaves as IDLE acceptance (back-to-back requests allowed).
    - else → IDLE.
- Latency (start accepted in cycle 0):
  - Direct hit at rotation r → done in cycle r+2.
  - No direct hit → done in cycle 17.
- Outputs are registered; valid/inv/shift_operand remain stable from done until the next accepted start.
- value==0 → direct hit at r=0, shift_operand=12'h000, valid=1.
- Multiple legal encodings exist → the smallest rotate_imm is reported.
- Round-trip invariant: when valid=1 and inv=0, the Val2 generator with imm=1 and this shift_operand produces the original value. When inv=1, it produces `~value`.

Test Plan:
- value=32'h000000FF, start → done in cycle 2, valid=1, inv=0, shift_operand=12'h0FF.
- value=32'hF000000F → done in cycle 4, shift_operand=12'h2FF. value=32'hFF000000 → done in cycle 6, shift_operand=12'h4FF. Both valid=1, inv=0.
- value=32'hFFFFFF00, ALLOW_INV=1 → done in cycle 17, valid=1, inv=1, shift_operand=12'h0FF. Same value with ALLOW_INV=0 → valid=0, shift_operand=12'h000.
- value=32'h00000101 (not encodable either way) → done in cycle 17, valid=0, inv=0, shift_operand=12'h000.
- Robustness: second start and a value change during SEARCH are ignored (result matches the first value). start asserted in the DONE cycle begins a new search immediately. rst=0 at cycle 5 of a search → all outputs 0 next cycle, no done, IDLE.
- Random sweep of 1000 values: every valid=1 result round-trips through the Val2 generator (imm=1). For every valid=0 result, an exhaustive 16-rotation reference model confirms no direct encoding exists (and, with ALLOW_INV=1, no inverted encoding).

Source files
------------

// File: rtl/operand2_encoder.sv
// rtl/operand2_encoder.sv - searches for the ARM rotate-immediate encoding of a 32-bit constant
// One rotation is tried per cycle; the lowest direct hit wins, an inverted (MVN) hit is the fallback.
module operand2_encoder #(
  parameter bit ALLOW_INV = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] value,
  output logic        busy,
  output logic        done,
  output logic        valid,
  output logic        inv,
  output logic [11:0] shift_operand
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SEARCH = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  logic [1:0]  state;
  logic [31:0] cap;
  logic [3:0]  r;
  logic        inv_found;
  logic [11:0] inv_rec;

  logic [4:0]  rot_amt;
  logic [5:0]  rot_back;
  logic [31:0] cap_n;
  logic [31:0] t_dir;
  logic [31:0] t_inv;
  logic        hit_dir;
  logic        hit_inv;

  // t = ROL(x, 2r); a shift by 32 yields zero, so r=0 degenerates to x itself
  always_comb begin
    rot_amt  = {r, 1'b0};
    rot_back = 6'd32 - {1'b0, rot_amt};
    cap_n    = ~cap;
    t_dir    = (cap << rot_amt) | (cap >> rot_back);
    t_inv    = (cap_n << rot_amt) | (cap_n >> rot_back);
    hit_dir  = (t_dir[31:8] == 24'd0);
    hit_inv  = (t_inv[31:8] == 24'd0);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      cap           <= 32'd0;
      r             <= 4'd0;
      inv_found     <= 1'b0;
      inv_rec       <= 12'd0;
      busy          <= 1'b0;
      done          <= 1'b0;
      valid         <= 1'b0;
      inv           <= 1'b0;
      shift_operand <= 12'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            cap           <= value;
            r             <= 4'd0;
            inv_found     <= 1'b0;
            inv_rec       <= 12'd0;
            valid         <= 1'b0;
            inv           <= 1'b0;
            shift_operand <= 12'd0;
            busy          <= 1'b1;
            state         <= SEARCH;
          end else begin
            state <= IDLE;
          end
        end
        SEARCH: begin
          if (hit_inv && !inv_found) begin
            inv_found <= 1'b1;
            inv_rec   <= {r, t_inv[7:0]};
          end
          if (hit_dir) begin
            shift_operand <= {r, t_dir[7:0]};
            valid         <= 1'b1;
            inv           <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b1;
            state         <= DONE;
          end else if (r != 4'd15) begin
            r <= r + 4'd1;
          end else begin
            // last rotation: the record may still be empty if only r=15 hits inverted
            if (ALLOW_INV && (inv_found || hit_inv)) begin
              shift_operand <= inv_found ? inv_rec : {r, t_inv[7:0]};
              valid         <= 1'b1;
              inv           <= 1'b1;
            end else begin
              shift_operand <= 12'd0;
              valid         <= 1'b0;
              inv           <= 1'b0;
            end
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_operand2_encoder.sv
// tb/tb_operand2_encoder.sv - directed table, corner sequences and reference-model sweep for operand2_encoder
module tb_operand2_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] value;
  logic        busy_a, done_a, valid_a, inv_a;
  logic [11:0] so_a;
  logic        busy_b, done_b, valid_b, inv_b;
  logic [11:0] so_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  operand2_encoder #(.ALLOW_INV(1'b1)) u_inv (
    .clk(clk), .rst(rst), .start(start), .value(value),
    .busy(busy_a), .done(done_a), .valid(valid_a), .inv(inv_a), .shift_operand(so_a)
  );

  operand2_encoder #(.ALLOW_INV(1'b0)) u_noinv (
    .clk(clk), .rst(rst), .start(start), .value(value),
    .busy(busy_b), .done(done_b), .valid(valid_b), .inv(inv_b), .shift_operand(so_b)
  );

  typedef struct {
    logic [31:0] value;
    int          lat;
    logic        va;
    logic        ia;
    logic [11:0] sa;
    logic        vb;
    logic        ib;
    logic [11:0] sb;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ror32(input logic [31:0] x, input int s);
    int k;
    k = s % 32;
    if (k == 0) return x;
    return (x >> k) | (x << (32 - k));
  endfunction

  function automatic logic [31:0] val2(input logic [11:0] so);
    return ror32({24'd0, so[7:0]}, 2 * so[11:8]);
  endfunction

  // Exhaustive reference: an encoding exists at rr iff decoding ROL(v,2rr)[7:0] restores v
  task automatic model(input logic [31:0] v, input bit allow, output logic vld, output logic iv,
                       output logic [11:0] so, output int lat);
    logic [31:0] t;
    logic [31:0] vn;
    bit          dfound;
    bit          ifound;
    logic [11:0] drec;
    logic [11:0] irec;
    dfound = 0; ifound = 0; drec = 12'd0; irec = 12'd0;
    vn = ~v;
    for (int rr = 0; rr < 16; rr++) begin
      t = ror32(v, 32 - 2 * rr);
      if (!dfound && ror32({24'd0, t[7:0]}, 2 * rr) == v) begin
        dfound = 1; drec = {4'(rr), t[7:0]};
      end
      t = ror32(vn, 32 - 2 * rr);
      if (!ifound && ror32({24'd0, t[7:0]}, 2 * rr) == vn) begin
        ifound = 1; irec = {4'(rr), t[7:0]};
      end
    end
    if (dfound) begin
      vld = 1; iv = 0; so = drec; lat = 2 + int'(drec[11:8]);
    end else if (ifound && allow) begin
      vld = 1; iv = 1; so = irec; lat = 17;
    end else begin
      vld = 0; iv = 0; so = 12'd0; lat = 17;
    end
  endtask

  // Called at a negedge; returns at the negedge where done is seen, lat = cycle index
  task automatic run_search(input logic [31:0] v, input bit disturb, output int lat);
    start = 1'b1;
    value = v;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    check("busy_in_search", {31'd0, busy_a}, 32'd1);
    check("valid_cleared", {31'd0, valid_a}, 32'd0);
    while (!done_a && lat < 40) begin
      if (disturb && lat == 2) begin
        start = 1'b1;
        value = ~v;
      end else if (disturb && lat == 3) begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    if (!done_a) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done within 40 cycles for value %h", v);
    end else begin
      check("done_b_aligned", {31'd0, done_b}, 32'd1);
      check("busy_low_at_done", {31'd0, busy_a}, 32'd0);
    end
  endtask

  initial begin
    int lat;
    int done_seen;
    logic        evld, eiv;
    logic [11:0] eso;
    int          elat;
    logic [31:0] v;

    vecs[0] = '{32'h000000FF, 2,  1, 0, 12'h0FF, 1, 0, 12'h0FF};
    vecs[1] = '{32'hF000000F, 4,  1, 0, 12'h2FF, 1, 0, 12'h2FF};
    vecs[2] = '{32'hFF000000, 6,  1, 0, 12'h4FF, 1, 0, 12'h4FF};
    vecs[3] = '{32'hFFFFFF00, 17, 1, 1, 12'h0FF, 0, 0, 12'h000};
    vecs[4] = '{32'h00000101, 17, 0, 0, 12'h000, 0, 0, 12'h000};
    vecs[5] = '{32'h00000000, 2,  1, 0, 12'h000, 1, 0, 12'h000};
    vecs[6] = '{32'h000003FC, 17, 1, 0, 12'hFFF, 1, 0, 12'hFFF};
    vecs[7] = '{32'hFFFFFFFF, 17, 1, 1, 12'h000, 0, 0, 12'h000};
    vecs[8] = '{32'hAB000000, 6,  1, 0, 12'h4AB, 1, 0, 12'h4AB};
    vecs[9] = '{32'h000000F0, 2,  1, 0, 12'h0F0, 1, 0, 12'h0F0};

    rst = 1'b0;
    start = 1'b0;
    value = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy_a}, 32'd0);
    check("rst_done", {31'd0, done_a}, 32'd0);
    check("rst_valid", {31'd0, valid_a}, 32'd0);
    check("rst_inv", {31'd0, inv_a}, 32'd0);
    check("rst_so", {20'd0, so_a}, 32'd0);
    check("rst_so_b", {20'd0, so_b}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      run_search(vecs[i].value, 1'b0, lat);
      check($sformatf("lat_%0d", i), lat, vecs[i].lat);
      check($sformatf("valid_a_%0d", i), {31'd0, valid_a}, {31'd0, vecs[i].va});
      check($sformatf("inv_a_%0d", i), {31'd0, inv_a}, {31'd0, vecs[i].ia});
      check($sformatf("so_a_%0d", i), {20'd0, so_a}, {20'd0, vecs[i].sa});
      check($sformatf("valid_b_%0d", i), {31'd0, valid_b}, {31'd0, vecs[i].vb});
      check($sformatf("inv_b_%0d", i), {31'd0, inv_b}, {31'd0, vecs[i].ib});
      check($sformatf("so_b_%0d", i), {20'd0, so_b}, {20'd0, vecs[i].sb});
      @(negedge clk);
      check($sformatf("done_pulse_%0d", i), {31'd0, done_a}, 32'd0);
      check($sformatf("so_held_%0d", i), {20'd0, so_a}, {20'd0, vecs[i].sa});
      check($sformatf("valid_held_%0d", i), {31'd0, valid_a}, {31'd0, vecs[i].va});
    end

    // second start and value change while busy must not disturb the search
    run_search(32'hFF000000, 1'b1, lat);
    check("disturb_lat", lat, 6);
    check("disturb_so", {20'd0, so_a}, 32'h4FF);
    check("disturb_valid", {31'd0, valid_a}, 32'd1);
    @(negedge clk);

    // back-to-back: start in the DONE cycle begins the next search immediately
    run_search(32'h000000FF, 1'b0, lat);
    check("b2b_first_so", {20'd0, so_a}, 32'h0FF);
    run_search(32'hF000000F, 1'b0, lat);
    check("b2b_lat", lat, 4);
    check("b2b_so", {20'd0, so_a}, 32'h2FF);
    @(negedge clk);

    // reset during cycle 5 of a search aborts it without a done
    start = 1'b1;
    value = 32'h00000101;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort_busy", {31'd0, busy_a}, 32'd0);
    check("abort_done", {31'd0, done_a}, 32'd0);
    check("abort_valid", {31'd0, valid_a}, 32'd0);
    check("abort_so", {20'd0, so_a}, 32'd0);
    rst = 1'b1;
    done_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (done_a || busy_a) done_seen++;
    end
    check("abort_stays_idle", done_seen, 0);

    for (int n = 0; n < 1000; n++) begin
      case (n % 3)
        0:       v = $urandom;
        1:       v = ror32({24'd0, 8'($urandom)}, 2 * int'($urandom_range(0, 15)));
        default: v = ~ror32({24'd0, 8'($urandom)}, 2 * int'($urandom_range(0, 15)));
      endcase
      run_search(v, 1'b0, lat);
      model(v, 1'b1, evld, eiv, eso, elat);
      check("sweep_lat", lat, elat);
      check("sweep_valid_a", {31'd0, valid_a}, {31'd0, evld});
      check("sweep_inv_a", {31'd0, inv_a}, {31'd0, eiv});
      check("sweep_so_a", {20'd0, so_a}, {20'd0, eso});
      if (valid_a)
        check("sweep_roundtrip_a", val2(so_a), inv_a ? ~v : v);
      model(v, 1'b0, evld, eiv, eso, elat);
      check("sweep_valid_b", {31'd0, valid_b}, {31'd0, evld});
      check("sweep_so_b", {20'd0, so_b}, {20'd0, eso});
      if (valid_b)
        check("sweep_roundtrip_b", val2(so_b), v);
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
